spi_sclk_gen: RTL and testbench
===============================

Name: spi_sclk_gen

Overview:
Parametrised SPI/QSPI serial-clock generator: the synthesizable, mode-aware successor to the simulation-only QSPI clock generator. It divides the system clock by a runtime divisor while chip-select is asserted, and supports all four CPOL/CPHA modes. It emits one-cycle sample/shift strobes for the shift-register datapath and stops itself after a programmed number of SCLK cycles. It sits between the QSPI controller FSM and the flash pins, and the flash testbenches also use it in place of the STARTUP-primitive clock.

Parameters:
DIV_WIDTH, 8, width of divisor input; half-period = div+1 system clocks
CNT_WIDTH, 16, width of SCLK-cycle counter and num_cycles
RESET_CPOL, 0, sclk value driven during and after reset, before the first cpol is latched

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cs  in  1  chip select, active-low; 1 = idle
div  in  DIV_WIDTH  half-period minus one; latched on transaction start
cpol  in  1  idle clock level; latched on transaction start
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on start
num_cycles  in  CNT_WIDTH  SCLK cycles per transaction; 0 = unlimited
sclk  out  1  serial clock (registered)
sample  out  1  one-cycle strobe: data-in sampling edge just occurred
shift  out  1  one-cycle strobe: data-out shifting edge just occurred
cycle_count  out  CNT_WIDTH  completed SCLK cycles in current transaction
busy  out  1  state == RUN
done  out  1  one-cycle pulse when num_cycles reached

Behaviour:
- Single clock domain. All outputs are registered. Reset values: sclk=RESET_CPOL, sample=0, shift=0, cycle_count=0, busy=0, done=0, state=IDLE, half-period counter=0.
- States: IDLE, RUN, HOLD.
- IDLE: counter=0, sclk=cpol_q. On the first edge with cs=0: latch div_q, cpol_q, cpha_q; drive sclk=cpol; clear cycle_count; go to RUN.
- RUN: counter increments each cycle. When counter >= div_q: counter<=0 and sclk toggles (edge event). Otherwise no edge.
  - First edge is registered div_q+1 cycles after entering RUN. Period = 2*(div_q+1) clocks; div=4 gives 10 MHz from 100 MHz.
  - Leading edge: sclk leaves cpol_q. Trailing edge: sclk returns to cpol_q.
  - sample is asserted in the same cycle as the registered edge when (leading && !cpha_q) || (trailing && cpha_q). shift is asserted on the other edge type. Exactly one of sample/shift fires per edge; both are 0 on non-edge cycles.
  - A trailing edge increments cycle_count. Wrap-around is modulo 2^CNT_WIDTH when num_cycles=0.
  - If num_cycles!=0 and the trailing edge makes cycle_count==num_cycles: done=1 for that cycle, go to HOLD. sclk is now at cpol_q.
- HOLD: no edges, sclk=cpol_q, busy=0, cycle_count holds its value. cs=1 returns the block to IDLE.
- cs=1 in any state: next cycle goes to IDLE, sclk=cpol_q, strobes=0, counter=0, cycle_count is not cleared until the next start. An aborted transaction raises no done.
- cs=1 takes priority over an edge or completion in the same cycle: no strobe and no done.
- Changes to div/cpol/cpha/num_cycles during RUN are ignored. Only the latched copies are used.
- div=0 is legal: sclk = clock/2, with a strobe on every cycle.
- reset asserted during RUN: next cycle all outputs return to reset values. A subsequent start requires cs sampled low after reset deasserts.

Decomposition:
- Shared package spi_pkg: sclk_state_e {IDLE, RUN, HOLD}; spi_mode_t struct {cpol, cpha}; localparams for the default divisor and the S25FL128S dummy-cycle counts (single mode 8, quad mode 6), reused by controller and testbench.
- One sub-module: spi_half_period_timer (counter, compare against div_q, edge pulse out).

Test Plan:
- Reset held 10 cycles, cs=0 -> sclk=0, busy=0, no strobes, cycle_count=0 throughout.
- div=4, cpol=0, cpha=0, num_cycles=8, cs low -> first rising edge 5 cycles after RUN; period 10; 8 sample pulses on rising edges and 8 shift pulses on falling edges; done pulses once with cycle_count=8; sclk=0 in HOLD.
- div=1, cpol=1, cpha=1, num_cycles=4 -> sclk idles 1, period 4; sample pulses only on rising (trailing) edges; done after 16 clocks in RUN.
- div=0, num_cycles=0, hold cs low for 2^CNT_WIDTH+3 cycles (CNT_WIDTH=4) -> sclk toggles every cycle; cycle_count wraps 15->0; done is never asserted.
- Mid-transaction abort: div=2, num_cycles=8, cs=1 after cycle_count=3 -> next cycle IDLE, sclk=cpol, no done; a restart clears cycle_count to 0.
- div changed 4->1 during RUN -> period stays at 10 clocks until the next cs falling start.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: SCLK generator states, mode bits and flash timing constants
// used by the QSPI controller, the clock generator and their testbenches.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sclk_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int unsigned DEFAULT_DIV        = 4;
    localparam int unsigned S25FL_DUMMY_SINGLE = 8;
    localparam int unsigned S25FL_DUMMY_QUAD   = 6;

    // Dummy cycles the S25FL128S inserts before read data, by bus width.
    function automatic int unsigned s25fl_dummy_cycles(input logic quad);
        return quad ? S25FL_DUMMY_QUAD : S25FL_DUMMY_SINGLE;
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period timer: counts system clocks while enabled and flags the cycle on
// which an SCLK edge is due (count reached div), restarting from zero after it.
module spi_half_period_timer
    import spi_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 edge_c_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    assign edge_c_o = en_i && (cnt_q >= div_i);

    always_comb begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        if (!en_i || edge_c_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// Mode-aware SPI/QSPI serial-clock generator: divides clock while cs is low, emits
// sample/shift strobes per edge and stops after a programmed number of SCLK cycles.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned DIV_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter logic        RESET_CPOL = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cs,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [CNT_WIDTH-1:0] num_cycles,
    output logic                 sclk,
    output logic                 sample,
    output logic                 shift,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic                 busy,
    output logic                 done
);

    sclk_state_e          state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    spi_mode_t            mode_q, mode_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 sample_q, sample_d;
    logic                 shift_q, shift_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 run_c;
    logic                 edge_c;
    logic                 trailing_c;
    logic                 complete_c;
    logic [CNT_WIDTH-1:0] cnt_inc_c;

    // cs high suppresses the timer so an abort never produces an edge.
    assign run_c      = (state_q == RUN) && !cs;
    assign trailing_c = (sclk_q != mode_q.cpol);
    assign cnt_inc_c  = cnt_q + CNT_WIDTH'(1);
    assign complete_c = edge_c && trailing_c && (num_q != '0) && (cnt_inc_c == num_q);

    spi_half_period_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_timer (
        .clk_i    (clock),
        .rst_i    (reset),
        .en_i     (run_c),
        .div_i    (div_q),
        .edge_c_o (edge_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cs) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     if (complete_c) state_d = HOLD;
                HOLD:    state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        div_d    = div_q;
        mode_d   = mode_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        sclk_d   = sclk_q;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        done_d   = 1'b0;
        busy_d   = (state_d == RUN);
        if (cs) begin
            sclk_d = mode_q.cpol;
        end else begin
            unique case (state_q)
                IDLE: begin
                    div_d  = div;
                    mode_d = '{cpol: cpol, cpha: cpha};
                    num_d  = num_cycles;
                    sclk_d = cpol;
                    cnt_d  = '0;
                end
                RUN: begin
                    if (edge_c) begin
                        sclk_d   = ~sclk_q;
                        sample_d = (trailing_c == mode_q.cpha);
                        shift_d  = (trailing_c != mode_q.cpha);
                        if (trailing_c) begin
                            cnt_d  = cnt_inc_c;
                            done_d = complete_c;
                        end
                    end
                end
                HOLD: begin
                    sclk_d = mode_q.cpol;
                end
                default: begin
                    sclk_d = mode_q.cpol;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q    <= '0;
            mode_q   <= '{cpol: RESET_CPOL, cpha: 1'b0};
            num_q    <= '0;
            cnt_q    <= '0;
            sclk_q   <= RESET_CPOL;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            mode_q   <= mode_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            sclk_q   <= sclk_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sclk        = sclk_q;
    assign sample      = sample_q;
    assign shift       = shift_q;
    assign cycle_count = cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: a per-cycle vector table for short transactions and
// closed-form expected waveforms for longer runs, mid-run input changes, wrap and abort.
module tb_spi_sclk_gen;
    import spi_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    logic          clock;
    logic          reset;
    logic          cs;
    logic [DW-1:0] div;
    logic          cpol;
    logic          cpha;
    logic [CW-1:0] num_cycles;
    logic          sclk;
    logic          sample;
    logic          shift;
    logic [CW-1:0] cycle_count;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    spi_sclk_gen #(
        .DIV_WIDTH  (DW),
        .CNT_WIDTH  (CW),
        .RESET_CPOL (1'b0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cs          (cs),
        .div         (div),
        .cpol        (cpol),
        .cpha        (cpha),
        .num_cycles  (num_cycles),
        .sclk        (sclk),
        .sample      (sample),
        .shift       (shift),
        .cycle_count (cycle_count),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          rst;
        logic          cs;
        logic [DW-1:0] div;
        logic          cpol;
        logic          cpha;
        logic [CW-1:0] num;
        logic          e_sclk;
        logic          e_sample;
        logic          e_shift;
        logic [CW-1:0] e_cnt;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int k, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d %s: got %0h expected %0h", nm, k, fld, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input int k, input logic e_sclk,
                             input logic e_sample, input logic e_shift,
                             input logic [CW-1:0] e_cnt, input logic e_busy,
                             input logic e_done);
        chk(nm, k, "sclk",        32'(sclk),        32'(e_sclk));
        chk(nm, k, "sample",      32'(sample),      32'(e_sample));
        chk(nm, k, "shift",       32'(shift),       32'(e_shift));
        chk(nm, k, "cycle_count", 32'(cycle_count), 32'(e_cnt));
        chk(nm, k, "busy",        32'(busy),        32'(e_busy));
        chk(nm, k, "done",        32'(done),        32'(e_done));
    endtask

    // Starts a transaction and checks nclk cycles against the ideal SCLK waveform;
    // at cycle chg_at every configuration input is changed, which must have no effect.
    task automatic run_model(input string nm, input int d, input logic cp, input logic ch,
                             input int n, input int nclk, input int chg_at);
        int   p;
        int   endk;
        int   e;
        logic hold;
        logic edg;
        logic lead;
        logic e_samp;
        logic e_shf;
        p    = d + 1;
        endk = 2 * p * n;
        cs = 1'b0; div = DW'(d); cpol = cp; cpha = ch; num_cycles = CW'(n);
        tick();
        check_all(nm, 0, cp, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 1; k <= nclk; k++) begin
            if (k == chg_at) begin
                div = DW'(1); cpol = ~cp; cpha = ~ch; num_cycles = CW'(3);
            end
            tick();
            hold   = (n != 0) && (k > endk);
            edg    = !hold && ((k % p) == 0);
            e      = hold ? 2 * n : k / p;
            lead   = 1'((e & 1));
            e_samp = edg && (lead ? !ch : ch);
            e_shf  = edg && !e_samp;
            check_all(nm, k, cp ^ 1'((e & 1)), e_samp, e_shf,
                      hold ? CW'(n) : CW'((k / (2 * p)) % 16),
                      !((n != 0) && (k >= endk)),
                      (n != 0) && (k == endk));
        end
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; div = '0; cpol = 1'b0; cpha = 1'b0; num_cycles = CW'(2);

        // Reset dominates a low cs.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("reset", i, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end

        // rst cs div cpol cpha num | sclk sample shift cnt busy done
        vecs[0]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            reset = vecs[i].rst; cs = vecs[i].cs; div = vecs[i].div;
            cpol = vecs[i].cpol; cpha = vecs[i].cpha; num_cycles = vecs[i].num;
            tick();
            check_all("vec", i, vecs[i].e_sclk, vecs[i].e_sample, vecs[i].e_shift,
                      vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_done);
        end

        // Mode 0, 10-clock period, 8 cycles; inputs changed mid-run are ignored.
        run_model("mode0", int'(DEFAULT_DIV), 1'b0, 1'b0, int'(S25FL_DUMMY_SINGLE), 84, 23);
        cs = 1'b1;
        tick();
        check_all("mode0_idle", 0, 1'b0, 1'b0, 1'b0, CW'(8), 1'b0, 1'b0);

        // Mode 3, 4-clock period, done after 16 clocks.
        run_model("mode3", 1, 1'b1, 1'b1, 4, 18, 0);
        cs = 1'b1;
        tick();
        check_all("mode3_idle", 0, 1'b1, 1'b0, 1'b0, CW'(4), 1'b0, 1'b0);

        // Abort lands on a trailing edge: no strobe, no count, no done.
        run_model("abort", 2, 1'b0, 1'b0, 8, 23, 0);
        cs = 1'b1;
        tick();
        check_all("abort", 24, 1'b0, 1'b0, 1'b0, CW'(3), 1'b0, 1'b0);
        tick();
        check_all("abort", 25, 1'b0, 1'b0, 1'b0, CW'(3), 1'b0, 1'b0);

        // Unlimited at div=0: edge every clock, counter wraps, never done.
        run_model("wrap", 0, 1'b0, 1'b0, 0, 38, 0);
        cs = 1'b1;
        tick();
        check_all("wrap_idle", 0, 1'b0, 1'b0, 1'b0, CW'(3), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
